phase_freq_detector: RTL and testbench

//  Front end of the ADPLL loop. Measures the phase error between ref_in and fb_in (the divided DCO clock), then filters it.

---
 rtl/adpll_pkg.sv | 17 +
 rtl/phase_freq_detector_if.sv | 38 +++
 rtl/edge_sync.sv | 28 ++
 rtl/phase_freq_detector.sv | 184 ++++++++++++++++++
 tb/tb_phase_freq_detector.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/adpll_pkg.sv
// Shared types and constants for the ADPLL phase/frequency detector.
package adpll_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REF_FIRST,
    FB_FIRST
  } pd_state_t;

  localparam int ERR_WIDTH_DEFAULT = 8;

  // Largest value the phase-error counter may hold before it sticks.
  function automatic int unsigned err_sat_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/phase_freq_detector_if.sv
// Signal bundle between the detector and its environment: the two async
// clock inputs and the step/measurement/lock outputs.
interface phase_freq_detector_if #(
  parameter int ERR_WIDTH = 8
) ();

  logic                 ref_in;
  logic                 fb_in;
  logic                 up_out;
  logic                 down_out;
  logic [ERR_WIDTH-1:0] phase_err;
  logic                 err_sign;
  logic                 err_valid;
  logic                 locked;

  modport slave (
    input  ref_in,
    input  fb_in,
    output up_out,
    output down_out,
    output phase_err,
    output err_sign,
    output err_valid,
    output locked
  );

  modport master (
    output ref_in,
    output fb_in,
    input  up_out,
    input  down_out,
    input  phase_err,
    input  err_sign,
    input  err_valid,
    input  locked
  );

endinterface

// File: rtl/edge_sync.sv
// Brings an asynchronous clock-like input into the clkUD domain and turns
// each of its rising edges into a single-cycle pulse.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  // Synchronizer chain followed by a registered rising-edge compare.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      last_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      last_q <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~last_q;
    end
  end

endmodule

// File: rtl/phase_freq_detector.sv
// ADPLL front end: measures the ref/fb edge separation in clkUD cycles,
// runs it through a random-walk filter to produce up/down steps, and
// tracks how long the error has stayed inside the lock window.
module phase_freq_detector
  import adpll_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ERR_WIDTH   = ERR_WIDTH_DEFAULT,
  parameter int FILTER_N    = 8,
  parameter int LOCK_WINDOW = 2,
  parameter int LOCK_COUNT  = 16
) (
  input logic                  clkUD,
  input logic                  reset,
  phase_freq_detector_if.slave bus
);

  localparam logic [ERR_WIDTH-1:0] ERR_MAX = ERR_WIDTH'(err_sat_max(ERR_WIDTH));
  localparam logic [ERR_WIDTH-1:0] WINDOW  = ERR_WIDTH'(LOCK_WINDOW);

  localparam int                   AW    = $clog2(FILTER_N) + 2;
  localparam logic signed [AW-1:0] LIMIT = AW'(FILTER_N);
  localparam logic signed [AW-1:0] ONE   = AW'(1);

  localparam int             LCW      = $clog2(LOCK_COUNT + 1);
  localparam logic [LCW-1:0] LOCK_MAX = LCW'(LOCK_COUNT);

  logic ref_rise;
  logic fb_rise;

  pd_state_t            state, state_n;
  logic [ERR_WIDTH-1:0] cnt, cnt_n, cnt_inc;
  logic                 emit;
  logic [ERR_WIDTH-1:0] emit_err;
  logic                 emit_sign;

  logic                 err_valid_q;
  logic [ERR_WIDTH-1:0] phase_err_q;
  logic                 err_sign_q;

  logic signed [AW-1:0] acc, acc_sum;
  logic                 up_q, down_q;

  logic [LCW-1:0]       lock_cnt, lock_cnt_inc;
  logic                 locked_q;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
    .clk      (clkUD),
    .reset    (reset),
    .async_in (bus.ref_in),
    .rise     (ref_rise)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
    .clk      (clkUD),
    .reset    (reset),
    .async_in (bus.fb_in),
    .rise     (fb_rise)
  );

  assign cnt_inc = (cnt == ERR_MAX) ? cnt : cnt + 1'b1;

  // Decide which edge opened the window, count its length, and close it.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    emit      = 1'b0;
    emit_err  = cnt;
    emit_sign = 1'b0;
    unique case (state)
      IDLE: begin
        if (ref_rise && fb_rise) begin
          emit     = 1'b1;
          emit_err = '0;
        end else if (ref_rise) begin
          state_n = REF_FIRST;
          cnt_n   = ERR_WIDTH'(1);
        end else if (fb_rise) begin
          state_n = FB_FIRST;
          cnt_n   = ERR_WIDTH'(1);
        end
      end
      REF_FIRST: begin
        cnt_n = cnt_inc;
        if (fb_rise) begin
          emit    = 1'b1;
          state_n = ref_rise ? REF_FIRST : IDLE;
          cnt_n   = ERR_WIDTH'(1);
        end else if (ref_rise) begin
          emit     = 1'b1;
          emit_err = ERR_MAX;
          cnt_n    = ERR_WIDTH'(1);
        end
      end
      FB_FIRST: begin
        cnt_n     = cnt_inc;
        emit_sign = 1'b1;
        if (ref_rise) begin
          emit    = 1'b1;
          state_n = fb_rise ? FB_FIRST : IDLE;
          cnt_n   = ERR_WIDTH'(1);
        end else if (fb_rise) begin
          emit     = 1'b1;
          emit_err = ERR_MAX;
          cnt_n    = ERR_WIDTH'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Measurement state and the registered error outputs.
  always_ff @(posedge clkUD) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      err_valid_q <= 1'b0;
      phase_err_q <= '0;
      err_sign_q  <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      err_valid_q <= emit;
      if (emit) begin
        phase_err_q <= emit_err;
        err_sign_q  <= emit_sign;
      end
    end
  end

  assign acc_sum = acc + (err_sign_q ? -ONE : ONE);

  // Random-walk filter: one step pulse per FILTER_N net votes in one direction.
  always_ff @(posedge clkUD) begin
    if (reset) begin
      acc    <= '0;
      up_q   <= 1'b0;
      down_q <= 1'b0;
    end else begin
      up_q   <= 1'b0;
      down_q <= 1'b0;
      if (err_valid_q && (phase_err_q != '0)) begin
        if (acc_sum == LIMIT) begin
          up_q <= 1'b1;
          acc  <= '0;
        end else if (acc_sum == -LIMIT) begin
          down_q <= 1'b1;
          acc    <= '0;
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end

  assign lock_cnt_inc = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + 1'b1;

  // Lock qualification: a run of small errors asserts locked, any large one clears it.
  always_ff @(posedge clkUD) begin
    if (reset) begin
      lock_cnt <= '0;
      locked_q <= 1'b0;
    end else if (err_valid_q) begin
      if (phase_err_q <= WINDOW) begin
        lock_cnt <= lock_cnt_inc;
        locked_q <= (lock_cnt_inc == LOCK_MAX);
      end else begin
        lock_cnt <= '0;
        locked_q <= 1'b0;
      end
    end
  end

  assign bus.up_out    = up_q;
  assign bus.down_out  = down_q;
  assign bus.phase_err = phase_err_q;
  assign bus.err_sign  = err_sign_q;
  assign bus.err_valid = err_valid_q;
  assign bus.locked    = locked_q;

endmodule

// File: tb/tb_phase_freq_detector.sv
// Randomized scoreboard bench for phase_freq_detector. Stimulus drives
// ref/fb waveforms and feeds the resulting edge times to an event-level
// model; a separate monitor checks every err_valid strobe, the step pulse
// and the lock level that follow it.
module tb_phase_freq_detector;

  localparam int ERR_W   = 8;
  localparam int SAT     = 255;
  localparam int FILT_N  = 8;
  localparam int WIN     = 2;
  localparam int LOCK_N  = 16;

  logic clkUD = 1'b0;
  logic reset = 1'b1;

  always #5 clkUD = ~clkUD;

  phase_freq_detector_if #(.ERR_WIDTH(ERR_W)) bus ();

  phase_freq_detector #(
    .SYNC_STAGES (2),
    .ERR_WIDTH   (ERR_W),
    .FILTER_N    (FILT_N),
    .LOCK_WINDOW (WIN),
    .LOCK_COUNT  (LOCK_N)
  ) dut (
    .clkUD (clkUD),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int err;
    bit sign;
    int pulse;
    bit lock;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  int cyc      = 0;
  bit prev_r   = 1'b0;
  bit prev_f   = 1'b0;
  int pend     = 0;
  int t0       = 0;
  int acc      = 0;
  int lock_cnt = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // One closed measurement: what err_valid carries, and what the filter and
  // lock detector must do as a consequence.
  function automatic void measure(input int e, input bit s);
    exp_t x;
    x.err   = e;
    x.sign  = s;
    x.pulse = 0;
    if (e != 0) acc += s ? -1 : 1;
    if (acc >= FILT_N) begin
      x.pulse = 1;
      acc = 0;
    end else if (acc <= -FILT_N) begin
      x.pulse = 2;
      acc = 0;
    end
    if (e <= WIN) lock_cnt = (lock_cnt < LOCK_N) ? lock_cnt + 1 : LOCK_N;
    else          lock_cnt = 0;
    x.lock = (lock_cnt == LOCK_N);
    exp_q.push_back(x);
  endfunction

  function automatic int sat(input int d);
    return (d > SAT) ? SAT : d;
  endfunction

  // Edge-pairing model in terms of edge timestamps.
  function automatic void modelEdges(input bit r, input bit f, input int t);
    if (!(r || f)) return;
    case (pend)
      0: begin
        if (r && f) measure(0, 1'b0);
        else begin
          pend = r ? 1 : 2;
          t0   = t;
        end
      end
      1: begin
        if (f) begin
          measure(sat(t - t0), 1'b0);
          pend = r ? 1 : 0;
        end else begin
          measure(SAT, 1'b0);
        end
        t0 = t;
      end
      default: begin
        if (r) begin
          measure(sat(t - t0), 1'b1);
          pend = f ? 2 : 0;
        end else begin
          measure(SAT, 1'b1);
        end
        t0 = t;
      end
    endcase
  endfunction

  task automatic driveCycle(input bit r, input bit f);
    @(negedge clkUD);
    bus.ref_in = r;
    bus.fb_in  = f;
    cyc++;
    modelEdges(r & ~prev_r, f & ~prev_f, cyc);
    prev_r = r;
    prev_f = f;
  endtask

  // n ref periods of length period; fb follows ref by offset cycles (negative: leads).
  task automatic applyStimulus(input int period, input int offset, input bit fb_on, input int n);
    int s;
    int len;
    int dr;
    int df;
    bit r;
    bit f;
    s   = 20;
    len = s + n * period + ((offset > 0) ? offset : 0) + 20;
    for (int c = 0; c < len; c++) begin
      dr = c - s;
      df = c - s - offset;
      r  = (dr >= 0) && (dr / period < n) && (dr % period < period / 2);
      f  = fb_on && (df >= 0) && (df / period < n) && (df % period < period / 2);
      driveCycle(r, f);
    end
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) driveCycle(1'b0, 1'b0);
    checkOutput("queue_drained", exp_q.size(), 0);
  endtask

  task automatic doReset();
    @(negedge clkUD);
    reset      = 1'b1;
    bus.ref_in = 1'b0;
    bus.fb_in  = 1'b0;
    prev_r     = 1'b0;
    prev_f     = 1'b0;
    pend       = 0;
    acc        = 0;
    lock_cnt   = 0;
    repeat (3) @(negedge clkUD);
    checkOutput("rst_up_out",    int'(bus.up_out),    0);
    checkOutput("rst_down_out",  int'(bus.down_out),  0);
    checkOutput("rst_phase_err", int'(bus.phase_err), 0);
    checkOutput("rst_err_sign",  int'(bus.err_sign),  0);
    checkOutput("rst_err_valid", int'(bus.err_valid), 0);
    checkOutput("rst_locked",    int'(bus.locked),    0);
    reset = 1'b0;
  endtask

  // Monitor: compare each strobe with the scoreboard, then the step/lock
  // reaction one cycle later.
  initial begin
    exp_t cur;
    bit   have_prev;
    int   step;
    have_prev = 1'b0;
    forever begin
      @(posedge clkUD);
      #1;
      step = bus.up_out ? 1 : (bus.down_out ? 2 : 0);
      checkOutput("up_down_exclusive", int'(bus.up_out & bus.down_out), 0);
      if (have_prev) begin
        checkOutput("step_pulse", step, cur.pulse);
        checkOutput("locked", int'(bus.locked), int'(cur.lock));
        have_prev = 1'b0;
      end else begin
        checkOutput("spurious_step", step, 0);
      end
      if (bus.err_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_err_valid", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          checkOutput("phase_err", int'(bus.phase_err), cur.err);
          checkOutput("err_sign", int'(bus.err_sign), int'(cur.sign));
          have_prev = 1'b1;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int p;
    int o;
    int n;
    bus.ref_in = 1'b0;
    bus.fb_in  = 1'b0;
    doReset();

    $display("[TB] fb lags by 5");
    applyStimulus(40, 5, 1'b1, 24);
    waitDrain();

    $display("[TB] fb leads by 3");
    applyStimulus(40, -3, 1'b1, 24);
    waitDrain();

    $display("[TB] coincident edges");
    applyStimulus(40, 0, 1'b1, 20);
    waitDrain();

    $display("[TB] fb held low, cycle slips");
    applyStimulus(20, 0, 1'b0, 20);
    waitDrain();

    $display("[TB] lag beyond counter range");
    applyStimulus(400, 300, 1'b1, 3);
    waitDrain();

    $display("[TB] randomized phase offsets");
    for (int k = 0; k < 6; k++) begin
      p = int'($urandom_range(30, 60));
      o = int'($urandom_range(0, 30)) - 15;
      n = int'($urandom_range(8, 20));
      applyStimulus(p, o, 1'b1, n);
    end
    waitDrain();

    $display("[TB] reset inside a measurement window");
    doReset();
    repeat (14) driveCycle(1'b1, 1'b0);
    doReset();
    applyStimulus(40, 1, 1'b1, 1);
    waitDrain();

    repeat (5) driveCycle(1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
